// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: three writeback requesters share the two
// write ports of the register file. Requesters 0/1 each need one port;
// requester 2 needs both unless its two destinations alias, in which case
// only data_b is written through one port. Rotating priority with a
// starvation override; port drive is registered one cycle after transfer.
//
// Arbiter state (rotating priority pointer ptr_q)
//   ptr | meaning
//   0   | order s0, s1, s2
//   1   | order s1, s2, s0
//   2   | order s2, s0, s1
module rf_write_arbiter #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s0_valid,
   output logic          s0_ready,
   input  logic [AW-1:0] s0_addr,
   input  logic [DW-1:0] s0_data,
   input  logic          s1_valid,
   output logic          s1_ready,
   input  logic [AW-1:0] s1_addr,
   input  logic [DW-1:0] s1_data,
   input  logic          s2_valid,
   output logic          s2_ready,
   input  logic [AW-1:0] s2_addr_a,
   input  logic [AW-1:0] s2_addr_b,
   input  logic [DW-1:0] s2_data_a,
   input  logic [DW-1:0] s2_data_b,
   output logic          reg_write,
   output logic          write_op2,
   output logic [AW-1:0] write_reg1,
   output logic [AW-1:0] write_reg2,
   output logic [DW-1:0] write_data1,
   output logic [DW-1:0] write_data2
);

   logic [1:0]      ptr_q;
   logic [2:0][1:0] wcnt_q;
   logic [2:0][1:0] base_ord;
   logic [2:0][1:0] ord;
   logic            ovr;
   logic [1:0]      ovr_idx;

   logic [2:0]      grant;
   logic [1:0]      nslot;
   logic            any_grant;
   logic [1:0]      first_idx;
   logic [AW-1:0]   p1_addr;
   logic [AW-1:0]   p2_addr;
   logic [DW-1:0]   p1_data;
   logic [DW-1:0]   p2_data;

   logic [1:0]      r;
   logic            rv;
   logic            dual;
   logic            fits;
   logic            conflict;
   logic [AW-1:0]   ra;
   logic [AW-1:0]   rb;
   logic [DW-1:0]   rda;
   logic [DW-1:0]   rdb;

   logic [2:0]      vld;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign vld = {s2_valid, s1_valid, s0_valid};

   // Priority order: rotation from ptr, with the lowest-index starved
   // requester pulled to the head and the others keeping their order.
   always_comb begin
      base_ord[0] = ptr_q;
      base_ord[1] = inc3(ptr_q);
      base_ord[2] = inc3(base_ord[1]);
      ord     = base_ord;
      ovr     = 1'b0;
      ovr_idx = 2'd0;
      if (wcnt_q[0] == 2'd3) begin
         ovr     = 1'b1;
         ovr_idx = 2'd0;
      end else if (wcnt_q[1] == 2'd3) begin
         ovr     = 1'b1;
         ovr_idx = 2'd1;
      end else if (wcnt_q[2] == 2'd3) begin
         ovr     = 1'b1;
         ovr_idx = 2'd2;
      end
      if (ovr) begin
         if (base_ord[1] == ovr_idx) begin
            ord[0] = ovr_idx;
            ord[1] = base_ord[0];
            ord[2] = base_ord[2];
         end else if (base_ord[2] == ovr_idx) begin
            ord[0] = ovr_idx;
            ord[1] = base_ord[0];
            ord[2] = base_ord[1];
         end
      end
   end

   // Single greedy pass over the order: grant when the slot need fits and
   // no destination collides with one already granted; no backtracking.
   always_comb begin
      grant     = 3'b000;
      nslot     = 2'd0;
      any_grant = 1'b0;
      first_idx = 2'd0;
      p1_addr   = '0;
      p2_addr   = '0;
      p1_data   = '0;
      p2_data   = '0;
      r         = 2'd0;
      rv        = 1'b0;
      dual      = 1'b0;
      fits      = 1'b0;
      conflict  = 1'b0;
      ra        = '0;
      rb        = '0;
      rda       = '0;
      rdb       = '0;
      for (int p = 0; p < 3; p++) begin
         r = ord[p];
         case (r)
            2'd0: begin
               rv   = s0_valid;
               ra   = s0_addr;
               rb   = s0_addr;
               rda  = s0_data;
               rdb  = s0_data;
               dual = 1'b0;
            end
            2'd1: begin
               rv   = s1_valid;
               ra   = s1_addr;
               rb   = s1_addr;
               rda  = s1_data;
               rdb  = s1_data;
               dual = 1'b0;
            end
            default: begin
               rv   = s2_valid;
               ra   = s2_addr_a;
               rb   = s2_addr_b;
               rda  = s2_data_a;
               rdb  = s2_data_b;
               dual = (s2_addr_a != s2_addr_b);
            end
         endcase
         // A dual write only fits into an empty cycle, so only single
         // writes can collide with an earlier grant.
         fits     = dual ? (nslot == 2'd0) : (nslot != 2'd2);
         conflict = (nslot == 2'd1) && (p1_addr == rb);
         if (rv && fits && !conflict) begin
            grant[r] = 1'b1;
            if (!any_grant) begin
               first_idx = r;
            end
            any_grant = 1'b1;
            if (dual) begin
               p1_addr = ra;
               p1_data = rda;
               p2_addr = rb;
               p2_data = rdb;
               nslot   = 2'd2;
            end else if (nslot == 2'd0) begin
               p1_addr = rb;
               p1_data = rdb;
               nslot   = 2'd1;
            end else begin
               p2_addr = rb;
               p2_data = rdb;
               nslot   = 2'd2;
            end
         end
      end
   end

   assign s0_ready = grant[0] & rst;
   assign s1_ready = grant[1] & rst;
   assign s2_ready = grant[2] & rst;

   // Register the write-port drive, priority pointer and wait counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write   <= 1'b0;
         write_op2   <= 1'b0;
         write_reg1  <= '0;
         write_reg2  <= '0;
         write_data1 <= '0;
         write_data2 <= '0;
         ptr_q       <= 2'd0;
         wcnt_q      <= '0;
      end else begin
         reg_write <= any_grant;
         write_op2 <= (nslot == 2'd2);
         if (nslot != 2'd0) begin
            write_reg1  <= p1_addr;
            write_data1 <= p1_data;
         end
         if (nslot == 2'd2) begin
            write_reg2  <= p2_addr;
            write_data2 <= p2_data;
         end
         if (any_grant) begin
            ptr_q <= inc3(first_idx);
         end
         for (int i = 0; i < 3; i++) begin
            if (grant[i] || !vld[i]) begin
               wcnt_q[i] <= 2'd0;
            end else if (wcnt_q[i] != 2'd3) begin
               wcnt_q[i] <= wcnt_q[i] + 2'd1;
            end
         end
      end
   end

endmodule
